// File: rtl/gshare_pkg.sv
// Shared definitions for the gshare direction predictor: FSM state codes,
// default tag layout, and the counter helper functions.
package gshare_pkg;

  // FSM state codes (two bits so the debug readout shows {30'b0, state})
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  // Default geometry; the predictor itself is parametrised.
  localparam int DEF_ROW_W = 8;
  localparam int DEF_COL_W = 2;
  localparam int DEF_CTR_W = 2;
  localparam int DEF_GHR_W = 8;

  // Tag layout at the default geometry, MSB first: {row, col, ctr, ghr}.
  typedef struct packed {
    logic [DEF_ROW_W-1:0] row;
    logic [DEF_COL_W-1:0] col;
    logic [DEF_CTR_W-1:0] ctr;
    logic [DEF_GHR_W-1:0] ghr;
  } gshare_tag_t;

  // Saturating +1 / -1 of a ctr_w-bit counter held in the low bits.
  function automatic logic [31:0] sat_update(input logic [31:0] ctr,
                                             input logic        inc,
                                             input int unsigned ctr_w);
    logic [31:0] max_v;
    max_v = (32'd1 << ctr_w) - 32'd1;
    if (inc) begin
      if (ctr >= max_v) sat_update = max_v;
      else              sat_update = ctr + 32'd1;
    end else begin
      if (ctr == 32'd0) sat_update = 32'd0;
      else              sat_update = ctr - 32'd1;
    end
  endfunction

  // Weakly-not-taken value: 2^(ctr_w-1)-1.
  function automatic logic [31:0] weak_nt(input int unsigned ctr_w);
    weak_nt = (32'd1 << (ctr_w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/gshare_ctr_ram.sv
// Simple dual-port counter table: registered read port with enable, one
// write port. A read and write to the same address in one cycle returns the
// old contents.
module gshare_ctr_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] r_rd_data;

  // Storage array write; contents survive reset (the sweep initialises them).
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Synchronous read sees the pre-write value on an address collision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/gshare_bpred.sv
// gshare direction predictor: hashed table lookup with a speculative global
// history, in-place counter update from execute via an opaque tag, GHR repair
// on mispredicts, a reset-time table sweep and statistics counters.
module gshare_bpred
  import gshare_pkg::*;
#(
  parameter int ROW_W = 8,
  parameter int COL_W = 2,
  parameter int CTR_W = 2,
  parameter int GHR_W = 8,
  // Derived; leave at its default.
  parameter int TAG_W = ROW_W + COL_W + CTR_W + GHR_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_init_busy,
  input  logic             i_lu_valid,
  output logic             o_lu_ready,
  input  logic [31:0]      i_lu_pc,
  input  logic             i_lu_is_branch,
  output logic             o_pred_valid,
  output logic             o_pred_dir,
  output logic [TAG_W-1:0] o_pred_tag,
  input  logic             i_up_valid,
  input  logic [TAG_W-1:0] i_up_tag,
  input  logic             i_up_dir,
  input  logic             i_up_miss,
  input  logic [1:0]       i_dbg_sel,
  output logic [31:0]      o_dbg_data
);

  localparam int IDX_W = ROW_W + COL_W;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [CTR_W-1:0] ctr;
    logic [GHR_W-1:0] ghr;
  } tag_t;

  // Registers
  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [GHR_W-1:0] r_ghr;
  logic             r_pred_valid;
  logic             r_lu_branch;
  logic [ROW_W-1:0] r_lu_row;
  logic [COL_W-1:0] r_lu_col;
  logic [GHR_W-1:0] r_lu_ghr;
  logic [31:0]      r_cnt_lu;
  logic [31:0]      r_cnt_up;
  logic [31:0]      r_cnt_miss;
  logic [31:0]      r_dbg_data;

  // Wires
  logic             w_run;
  logic             w_lu_ready;
  logic             w_lu_fire;
  logic             w_up_fire;
  logic             w_repair;
  tag_t             w_up_tag;
  logic [CTR_W-1:0] w_ctr;
  logic             w_pred_dir;
  logic [GHR_W-1:0] w_ghr_spec;
  logic [GHR_W-1:0] w_ghr_fix;
  logic [GHR_W-1:0] w_ghr_eff;
  logic [ROW_W-1:0] w_ghr_ext;
  logic [ROW_W-1:0] w_lu_row;
  logic [COL_W-1:0] w_lu_col;
  logic [31:0]      w_sat_full;
  logic [31:0]      w_weak_full;
  logic [CTR_W-1:0] w_sat;
  logic [CTR_W-1:0] w_weak;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_addr;
  logic [CTR_W-1:0] w_wr_data;
  logic             w_unused_bits;

  assign w_run      = (r_state == ST_RUN);
  assign w_repair   = i_up_valid & i_up_miss;
  assign w_lu_ready = w_run & ~w_repair;
  assign w_lu_fire  = i_lu_valid & w_lu_ready;
  assign w_up_fire  = i_up_valid & w_run;
  assign w_up_tag   = i_up_tag;

  assign w_pred_dir = r_lu_branch & w_ctr[CTR_W-1];

  // History shift helpers; a 1-bit history just takes the new direction.
  if (GHR_W > 1) begin : g_ghr_shift
    assign w_ghr_spec = {r_ghr[GHR_W-2:0], w_pred_dir};
    assign w_ghr_fix  = {w_up_tag.ghr[GHR_W-2:0], i_up_dir};
  end else begin : g_ghr_bit
    assign w_ghr_spec = w_pred_dir;
    assign w_ghr_fix  = i_up_dir;
  end

  // Effective history this cycle: includes the branch whose counter MSB is
  // being returned now, so back-to-back lookups see its predicted outcome.
  always_comb begin
    w_ghr_eff = r_ghr;
    if (r_pred_valid & r_lu_branch) w_ghr_eff = w_ghr_spec;
    else                            w_ghr_eff = r_ghr;
  end

  // Zero-extend the history to row width for the index hash.
  always_comb begin
    w_ghr_ext = '0;
    w_ghr_ext[GHR_W-1:0] = w_ghr_eff;
  end

  assign w_lu_row = i_lu_pc[ROW_W+COL_W+1:COL_W+2] ^ w_ghr_ext;
  assign w_lu_col = i_lu_pc[COL_W+1:2];

  assign w_sat_full  = sat_update({{(32-CTR_W){1'b0}}, w_up_tag.ctr}, i_up_dir, CTR_W);
  assign w_weak_full = weak_nt(CTR_W);
  assign w_sat       = w_sat_full[CTR_W-1:0];
  assign w_weak      = w_weak_full[CTR_W-1:0];

  // Table write source: sweep during INIT, resolved-branch update in RUN.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    w_wr_data = '0;
    case (r_state)
      ST_INIT: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_idx;
        w_wr_data = w_weak;
      end
      ST_RUN: begin
        w_wr_en   = i_up_valid;
        w_wr_addr = {w_up_tag.row, w_up_tag.col};
        w_wr_data = w_sat;
      end
      default: begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
      end
    endcase
  end

  gshare_ctr_ram #(
    .ADDR_W (IDX_W),
    .DATA_W (CTR_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rd_en   (w_lu_fire),
    .i_rd_addr ({w_lu_row, w_lu_col}),
    .o_rd_data (w_ctr),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data)
  );

  // FSM and sweep index: INIT walks every entry once, then RUN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_idx <= r_idx + IDX_ONE;
          if (r_idx == IDX_LAST) r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_INIT;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // Global history: mispredict repair wins over the speculative shift.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_ghr <= '0;
    else if (w_up_fire & i_up_miss) r_ghr <= w_ghr_fix;
    else                            r_ghr <= w_ghr_eff;
  end

  // Lookup pipeline stage: capture index/history for the result cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pred_valid <= 1'b0;
      r_lu_branch  <= 1'b0;
      r_lu_row     <= '0;
      r_lu_col     <= '0;
      r_lu_ghr     <= '0;
    end else begin
      r_pred_valid <= w_lu_fire;
      if (w_lu_fire) begin
        r_lu_branch <= i_lu_is_branch;
        r_lu_row    <= w_lu_row;
        r_lu_col    <= w_lu_col;
        r_lu_ghr    <= w_ghr_eff;
      end
    end
  end

  // Statistics counters, free-running with wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_lu   <= 32'd0;
      r_cnt_up   <= 32'd0;
      r_cnt_miss <= 32'd0;
    end else begin
      if (w_lu_fire & i_lu_is_branch) r_cnt_lu <= r_cnt_lu + 32'd1;
      if (w_up_fire)                  r_cnt_up <= r_cnt_up + 32'd1;
      if (w_up_fire & i_up_miss)      r_cnt_miss <= r_cnt_miss + 32'd1;
    end
  end

  // Registered debug readout.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dbg_data <= 32'd0;
    end else begin
      case (i_dbg_sel)
        2'd0:    r_dbg_data <= r_cnt_lu;
        2'd1:    r_dbg_data <= r_cnt_up;
        2'd2:    r_dbg_data <= r_cnt_miss;
        2'd3:    r_dbg_data <= {30'd0, r_state};
        default: r_dbg_data <= 32'd0;
      endcase
    end
  end

  assign o_init_busy  = (r_state == ST_INIT);
  assign o_lu_ready   = w_lu_ready;
  assign o_pred_valid = r_pred_valid;
  assign o_pred_dir   = w_pred_dir;
  assign o_pred_tag   = {r_lu_row, r_lu_col, w_ctr, r_lu_ghr};
  assign o_dbg_data   = r_dbg_data;

  // PC bits outside the index and wide helper results are intentionally dropped.
  assign w_unused_bits = ^{i_lu_pc[31:ROW_W+COL_W+2], i_lu_pc[1:0],
                           w_sat_full[31:CTR_W], w_weak_full[31:CTR_W],
                           w_up_tag.ghr};

endmodule

// File: tb/tb_gshare_bpred.sv
// Scoreboard bench for gshare_bpred at default geometry: stimulus pushes the
// hand-computed {dir, tag} for each accepted lookup, a monitor pops on
// pred_valid and compares.
module tb_gshare_bpred;

  logic        clk;
  logic        rst_n;
  logic        init_busy;
  logic        lu_valid;
  logic        lu_ready;
  logic [31:0] lu_pc;
  logic        lu_is_branch;
  logic        pred_valid;
  logic        pred_dir;
  logic [19:0] pred_tag;
  logic        up_valid;
  logic [19:0] up_tag;
  logic        up_dir;
  logic        up_miss;
  logic [1:0]  dbg_sel;
  logic [31:0] dbg_data;

  int total;
  int bad;
  logic [20:0] sb_q[$];
  logic [20:0] m_exp;

  gshare_bpred dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .o_init_busy    (init_busy),
    .i_lu_valid     (lu_valid),
    .o_lu_ready     (lu_ready),
    .i_lu_pc        (lu_pc),
    .i_lu_is_branch (lu_is_branch),
    .o_pred_valid   (pred_valid),
    .o_pred_dir     (pred_dir),
    .o_pred_tag     (pred_tag),
    .i_up_valid     (up_valid),
    .i_up_tag       (up_tag),
    .i_up_dir       (up_dir),
    .i_up_miss      (up_miss),
    .i_dbg_sel      (dbg_sel),
    .o_dbg_data     (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] mk_tag(input logic [7:0] row, input logic [1:0] col,
                                         input logic [1:0] ctr, input logic [7:0] ghr);
    return {row, col, ctr, ghr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each presented prediction against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && pred_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pred_unexpected: got dir=%0d tag=%0h expected no result", pred_dir, pred_tag);
      end else begin
        m_exp = sb_q.pop_front();
        chk("pred_dir_tag", {11'd0, pred_dir, pred_tag}, {11'd0, m_exp});
      end
    end
  end

  task automatic drive(input logic lv, input logic [31:0] pc, input logic br,
                       input logic uv, input logic [19:0] ut, input logic ud, input logic um);
    lu_valid = lv; lu_pc = pc; lu_is_branch = br;
    up_valid = uv; up_tag = ut; up_dir = ud; up_miss = um;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 20'd0, 1'b0, 1'b0);
  endtask

  task automatic lookup(input logic [31:0] pc, input logic br,
                        input logic exp_dir, input logic [19:0] exp_tag);
    sb_q.push_back({exp_dir, exp_tag});
    drive(1'b1, pc, br, 1'b0, 20'd0, 1'b0, 1'b0);
  endtask

  task automatic update(input logic [19:0] ut, input logic ud);
    drive(1'b0, 32'd0, 1'b0, 1'b1, ut, ud, 1'b0);
  endtask

  task automatic dbg(input string name, input logic [1:0] sel, input logic [31:0] exp);
    dbg_sel = sel;
    @(posedge clk); #1;
    chk(name, dbg_data, exp);
  endtask

  task automatic wait_init(input string name, input int exp_cycles);
    int cnt;
    cnt = 0;
    while (init_busy === 1'b1 && cnt < 3000) begin
      @(posedge clk); #1;
      cnt++;
    end
    lu_valid = 1'b0; up_valid = 1'b0; up_miss = 1'b0; up_dir = 1'b0;
    #1;
    chk(name, cnt, exp_cycles);
    chk({name, "_ready"}, {31'd0, lu_ready}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] ii;
    total = 0; bad = 0;
    rst_n = 1'b0; dbg_sel = 2'd0;
    lu_valid = 1'b0; lu_pc = 32'd0; lu_is_branch = 1'b0;
    up_valid = 1'b0; up_tag = 20'd0; up_dir = 1'b0; up_miss = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_busy", {31'd0, init_busy}, 32'd1);
    chk("rst_lu_ready", {31'd0, lu_ready}, 32'd0);
    chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
    chk("rst_pred_dir", {31'd0, pred_dir}, 32'd0);
    chk("rst_pred_tag", {12'd0, pred_tag}, 32'd0);
    rst_n = 1'b1;
    wait_init("init_cycles", 1024);
    dbg("dbg_state_run", 2'd3, 32'd1);

    // Every entry reads weakly-not-taken (non-branch lookups keep ghr at 0)
    for (int i = 0; i < 1024; i++) begin
      ii = i[9:0];
      lookup({20'd0, ii, 2'd0}, 1'b0, 1'b0, {ii, 2'b01, 8'h00});
    end
    idle();
    dbg("dbg_lookups_nb", 2'd0, 32'd0);

    // Training at PC 0x40 (row 4, col 0), counter 01->10->11->11
    lookup(32'h40, 1'b1, 1'b0, mk_tag(8'h04, 2'd0, 2'd1, 8'h00));
    update(mk_tag(8'h04, 2'd0, 2'd1, 8'h00), 1'b1);
    lookup(32'h40, 1'b0, 1'b0, mk_tag(8'h04, 2'd0, 2'd2, 8'h00));
    update(mk_tag(8'h04, 2'd0, 2'd2, 8'h00), 1'b1);
    lookup(32'h40, 1'b0, 1'b0, mk_tag(8'h04, 2'd0, 2'd3, 8'h00));
    update(mk_tag(8'h04, 2'd0, 2'd3, 8'h00), 1'b1);
    lookup(32'h40, 1'b0, 1'b0, mk_tag(8'h04, 2'd0, 2'd3, 8'h00));

    // Two back-to-back predicted-taken branches: ghr 00 -> 01 -> 03
    lookup(32'h40, 1'b1, 1'b1, mk_tag(8'h04, 2'd0, 2'd3, 8'h00));
    lookup(32'h50, 1'b1, 1'b1, mk_tag(8'h04, 2'd0, 2'd3, 8'h01));
    lookup(32'h40, 1'b0, 1'b0, mk_tag(8'h07, 2'd0, 2'd1, 8'h03));

    // Mispredict repair: ghr -> 00, lookup blocked, entry (4,0) 3 -> 2
    lu_valid = 1'b1; lu_pc = 32'h40; lu_is_branch = 1'b1;
    up_valid = 1'b1; up_tag = mk_tag(8'h04, 2'd0, 2'd3, 8'h00); up_dir = 1'b0; up_miss = 1'b1;
    #1;
    chk("miss_lu_ready", {31'd0, lu_ready}, 32'd0);
    @(posedge clk); #1;
    lookup(32'h40, 1'b0, 1'b0, mk_tag(8'h04, 2'd0, 2'd2, 8'h00));

    // Same-cycle update and lookup of entry (5,1): old value then new
    sb_q.push_back({1'b0, mk_tag(8'h05, 2'd1, 2'd1, 8'h00)});
    drive(1'b1, 32'h54, 1'b0, 1'b1, mk_tag(8'h05, 2'd1, 2'd1, 8'h00), 1'b1, 1'b0);
    lookup(32'h54, 1'b0, 1'b0, mk_tag(8'h05, 2'd1, 2'd2, 8'h00));

    // Saturation at zero on entry (6,0)
    update(mk_tag(8'h06, 2'd0, 2'd0, 8'h00), 1'b0);
    lookup(32'h60, 1'b0, 1'b0, mk_tag(8'h06, 2'd0, 2'd0, 8'h00));
    idle();

    dbg("dbg_lookups", 2'd0, 32'd3);
    dbg("dbg_updates", 2'd1, 32'd6);
    dbg("dbg_misses", 2'd2, 32'd1);
    dbg("dbg_state", 2'd3, 32'd1);

    // Reset, then re-reset at sweep index 300; updates during INIT are dropped
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst2_init_busy", {31'd0, init_busy}, 32'd1);
    chk("rst2_pred_valid", {31'd0, pred_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    lu_valid = 1'b1; lu_pc = 32'h40; lu_is_branch = 1'b1;
    up_valid = 1'b1; up_tag = mk_tag(8'h05, 2'd1, 2'd3, 8'h55); up_dir = 1'b1; up_miss = 1'b1;
    #1;
    chk("init_lu_ready", {31'd0, lu_ready}, 32'd0);
    wait_init("reinit_cycles", 1024);
    dbg("dbg_updates_init", 2'd1, 32'd0);
    dbg("dbg_misses_init", 2'd2, 32'd0);
    lookup(32'h40, 1'b1, 1'b0, mk_tag(8'h04, 2'd0, 2'd1, 8'h00));
    lookup(32'h54, 1'b0, 1'b0, mk_tag(8'h05, 2'd1, 2'd1, 8'h00));
    idle();
    dbg("dbg_lookups_reinit", 2'd0, 32'd1);

    repeat (3) idle();
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gshare_bpred.md
# gshare_bpred

Parametrised successor of the fetch-stage bimodal predictor. It predicts direction only, using a gshare table of saturating counters:
- row index = PC row bits XOR a speculative global history register (GHR);
- column = PC low word bits;
- in-place update arrives from execute through an opaque tag, so no read-modify-write is needed.

After reset it clears the table with a hardware sweep, repairs the GHR on mispredicts, and keeps lookup/update/miss statistics. It sits between fetch, which supplies the predecoded branch flag, and execute.

## Interface
Parameters:
- ROW_W, 8: log2 rows.
- COL_W, 2: log2 counters per row; counters = 2^(ROW_W+COL_W).
- CTR_W, 2: counter width, >= 2.
- GHR_W, 8: history length; constrained 1 <= GHR_W <= ROW_W.
- TAG_W, derived: ROW_W+COL_W+CTR_W+GHR_W.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- init_busy  out  1  table sweep in progress.
- lu_valid  in  1  lookup request.
- lu_ready  out  1  lookup accepted when lu_valid & lu_ready.
- lu_pc  in  32  fetch PC.
- lu_is_branch  in  1  predecoded conditional branch.
- pred_valid  out  1  prediction result valid.
- pred_dir  out  1  predicted taken.
- pred_tag  out  TAG_W  {row, col, ctr, ghr_snapshot}; carried to execute unchanged.
- up_valid  in  1  resolved branch.
- up_tag  in  TAG_W  tag of the resolved branch.
- up_dir  in  1  actual direction.
- up_miss  in  1  direction mispredicted.
- dbg_sel  in  2  selects dbg_data: 0 lookups, 1 updates, 2 misses, 3 {30'b0, state}.
- dbg_data  out  32  statistics readout.

## Operation
- States:
  - INIT: sweep idx 0..2^(ROW_W+COL_W)-1, one entry per cycle. Each entry is written with 2^(CTR_W-1)-1 (weakly not-taken). After the last index, go to RUN.
  - RUN: normal operation.
- lu_ready = (state==RUN) & ~(up_valid & up_miss).
- Lookup, on an accepted request:
  - row = lu_pc[ROW_W+COL_W+1:COL_W+2] ^ zero-extended ghr;
  - col = lu_pc[COL_W+1:2].
- Result, one cycle after acceptance:
  - ctr = table[{row,col}];
  - pred_dir = lu_is_branch_r & ctr[CTR_W-1];
  - pred_tag = {row, col, ctr, ghr used for the lookup}.
- Speculative GHR: on an accepted lookup with lu_is_branch=1, ghr <= {ghr[GHR_W-2:0], predicted dir}. The shift takes effect in the cycle pred_valid is high (the counter MSB is known then).
- Update, when up_valid and state==RUN:
  - write table[{tag.row, tag.col}] <= sat(tag.ctr ± 1), +1 if up_dir, -1 otherwise;
  - saturate at 0 and at 2^CTR_W-1.
- Repair: when up_valid & up_miss, ghr <= {tag.ghr[GHR_W-2:0], up_dir}. Repair overrides any same-cycle speculative shift.
- up_valid during INIT is dropped: no write, no count.
- Statistics: 32-bit counters, wrap on overflow, cleared by reset.
  - lookups counts accepted lookups with lu_is_branch.
  - updates counts up_valid in RUN.
  - misses counts up_valid & up_miss in RUN.

## Timing
- Reset (asynchronous assert) forces:
  - state=INIT, sweep idx=0, ghr=0, counters=0;
  - init_busy=1, lu_ready=0, pred_valid=0, pred_dir=0, pred_tag=0.
- Sweep: init_busy falls exactly 2^(ROW_W+COL_W) cycles after reset deassert. lu_ready can rise the same cycle.
- Lookup latency is 1 cycle: pred_valid is high for one cycle per accepted request. There is no backpressure on the result.
- Update write latency is 1 cycle. A lookup reading the same entry in the same cycle as the write returns the old value (read-before-write).
- A repaired GHR is used by the first lookup accepted after the repair cycle.
- Reset asserted mid-sweep or mid-operation restarts INIT from index 0. Table contents are not otherwise cleared.

## Structure
- Shared package gshare_pkg holds:
  - the tag struct {row, col, ctr, ghr};
  - state enum INIT/RUN;
  - the saturating-increment function;
  - the weak-not-taken constant expression.
- One sub-module, gshare_ctr_ram: simple dual-port table of 2^(ROW_W+COL_W) x CTR_W. It has a synchronous read port and a write port, with old data returned on same-address collision.
- The FSM, GHR, index hash and statistics live in gshare_bpred.

## Test plan
- Reset then idle, default params:
  - init_busy high for 1024 cycles, then low;
  - every entry reads 2'b01;
  - dbg_sel=3 shows 1.
- Branch at PC 0x40, ghr=0, 3 updates with up_dir=1:
  - ctr goes 01->10->11->11 (saturates);
  - next lookup gives pred_dir=1, tag.ctr=3.
- Lookup with lu_is_branch=0 at PC 0x40 after training: pred_dir=0, ghr unchanged, lookups counter unchanged.
- Two predicted-taken branches, ghr 0x00->0x01->0x03, then up_miss with tag.ghr=0x00, up_dir=0:
  - ghr=0x00, lu_ready low that cycle;
  - misses=1.
- Same-cycle update and lookup to entry {row 5, col 1}: lookup returns the pre-update ctr, and the following lookup returns the updated one.
- Reset pulsed at sweep index 300: sweep restarts at 0, and init_busy stays high for a further 1024 cycles.
